hamming_secded_pipe: RTL and testbench

//  Pipelined, parametrised SECDED Hamming codec with valid/ready handshakes, used around
//  SEU-exposed storage. The encode channel turns data into an extended Hamming codeword.
//  The decode channel checks a codeword, corrects single errors and flags double errors.

---
 rtl/hamming_secded_pipe.sv | 178 +++++++++++++++++
 tb/tb_hamming_secded_pipe.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_secded_pipe.sv
// rtl/hamming_secded_pipe.sv - pipelined SECDED Hamming encoder/decoder with saturating error counters
// Optional HAMMING_ERR_INJECT_EN adds a one-shot codeword error-injection path on the encode channel.
module hamming_secded_pipe #(
  parameter int PARITY_BITS = 4,
  parameter int DATA_WIDTH  = (1 << PARITY_BITS) - PARITY_BITS - 1,
  parameter int CODE_WIDTH  = (1 << PARITY_BITS),
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enc_valid_i,
  output logic                   enc_ready_o,
  input  logic [DATA_WIDTH-1:0]  enc_data_i,
  output logic                   cw_valid_o,
  input  logic                   cw_ready_i,
  output logic [CODE_WIDTH-1:0]  cw_o,
  input  logic                   dec_valid_i,
  output logic                   dec_ready_o,
  input  logic [CODE_WIDTH-1:0]  dec_cw_i,
  output logic                   dec_valid_o,
  input  logic                   dec_ready_i,
  output logic [DATA_WIDTH-1:0]  dec_data_o,
  output logic                   dec_corr_o,
  output logic                   dec_uncorr_o,
  output logic [PARITY_BITS-1:0] dec_synd_o,
  input  logic                   clr_cnt_i,
  output logic [CNT_WIDTH-1:0]   ce_cnt_o,
  output logic [CNT_WIDTH-1:0]   ue_cnt_o
`ifdef HAMMING_ERR_INJECT_EN
  ,
  input  logic                   inj_arm_i,
  input  logic [CODE_WIDTH-1:0]  inj_mask_i,
  output logic                   inj_pend_o
`endif
);

  function automatic logic [PARITY_BITS-1:0] synd_of(input logic [CODE_WIDTH-1:0] cw);
    logic [PARITY_BITS-1:0] s;
    s = '0;
    for (int i = 1; i < CODE_WIDTH; i++)
      if (cw[i]) s = s ^ PARITY_BITS'(i);
    return s;
  endfunction

  // Data bit for non-power-of-two position i sits at index i - clog2(i) - 1.
  function automatic logic [CODE_WIDTH-1:0] place(input logic [DATA_WIDTH-1:0] d);
    logic [CODE_WIDTH-1:0] cw;
    cw = '0;
    for (int i = 3; i < CODE_WIDTH; i++)
      if ((i & (i - 1)) != 0) cw[i] = d[i - $clog2(i) - 1];
    return cw;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] extract(input logic [CODE_WIDTH-1:0] cw);
    logic [DATA_WIDTH-1:0] d;
    d = '0;
    for (int i = 3; i < CODE_WIDTH; i++)
      if ((i & (i - 1)) != 0) d[i - $clog2(i) - 1] = cw[i];
    return d;
  endfunction

  // The syndrome of the data-only word is exactly the parity vector that zeroes it.
  function automatic logic [CODE_WIDTH-1:0] encode(input logic [DATA_WIDTH-1:0] d);
    logic [CODE_WIDTH-1:0]  cw;
    logic [PARITY_BITS-1:0] s;
    cw = place(d);
    s  = synd_of(cw);
    for (int k = 0; k < PARITY_BITS; k++) cw[1 << k] = s[k];
    cw[0] = ^cw[CODE_WIDTH-1:1];
    return cw;
  endfunction

  logic                  enc_fire;
  logic [CODE_WIDTH-1:0] inj_eff;

  assign enc_ready_o = !cw_valid_o | cw_ready_i;
  assign enc_fire    = enc_valid_i & enc_ready_o;

`ifdef HAMMING_ERR_INJECT_EN
  logic [CODE_WIDTH-1:0] inj_mask_q;

  always_comb begin
    inj_eff = '0;
    if (inj_arm_i)       inj_eff = inj_mask_i;
    else if (inj_pend_o) inj_eff = inj_mask_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inj_pend_o <= 1'b0;
      inj_mask_q <= '0;
    end else begin
      if (inj_arm_i) inj_mask_q <= inj_mask_i;
      if (enc_fire)       inj_pend_o <= 1'b0;
      else if (inj_arm_i) inj_pend_o <= 1'b1;
    end
  end
`else
  assign inj_eff = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cw_valid_o <= 1'b0;
      cw_o       <= '0;
    end else if (enc_fire) begin
      cw_valid_o <= 1'b1;
      cw_o       <= encode(enc_data_i) ^ inj_eff;
    end else if (cw_ready_i) begin
      cw_valid_o <= 1'b0;
    end
  end

  logic                   s1_valid;
  logic [CODE_WIDTH-1:0]  s1_cw;
  logic [PARITY_BITS-1:0] s1_synd;
  logic                   s1_par;
  logic                   s2_ready;
  logic                   dec_fire;
  logic                   out_fire;
  logic [CODE_WIDTH-1:0]  fix_cw;

  assign s2_ready    = !dec_valid_o | dec_ready_i;
  assign dec_ready_o = !s1_valid | s2_ready;
  assign dec_fire    = dec_valid_i & dec_ready_o;
  assign out_fire    = dec_valid_o & dec_ready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_cw    <= '0;
      s1_synd  <= '0;
      s1_par   <= 1'b0;
    end else if (dec_fire) begin
      s1_valid <= 1'b1;
      s1_cw    <= dec_cw_i;
      s1_synd  <= synd_of(dec_cw_i);
      s1_par   <= ^dec_cw_i;
    end else if (s2_ready) begin
      s1_valid <= 1'b0;
    end
  end

  // Only odd overall parity with a nonzero syndrome points at a flippable position.
  always_comb begin
    fix_cw = s1_cw;
    if (s1_par && (s1_synd != '0)) fix_cw[s1_synd] = ~s1_cw[s1_synd];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dec_valid_o  <= 1'b0;
      dec_data_o   <= '0;
      dec_corr_o   <= 1'b0;
      dec_uncorr_o <= 1'b0;
      dec_synd_o   <= '0;
    end else if (s1_valid && s2_ready) begin
      dec_valid_o  <= 1'b1;
      dec_data_o   <= extract(fix_cw);
      dec_corr_o   <= s1_par;
      dec_uncorr_o <= !s1_par && (s1_synd != '0);
      dec_synd_o   <= s1_synd;
    end else if (dec_ready_i) begin
      dec_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_cnt_i) begin
      ce_cnt_o <= '0;
      ue_cnt_o <= '0;
    end else if (out_fire) begin
      if (dec_corr_o && !(&ce_cnt_o))   ce_cnt_o <= ce_cnt_o + CNT_WIDTH'(1);
      if (dec_uncorr_o && !(&ue_cnt_o)) ue_cnt_o <= ue_cnt_o + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_hamming_secded_pipe.sv
// tb/tb_hamming_secded_pipe.sv - scoreboard bench for hamming_secded_pipe (P=4)
module tb_hamming_secded_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enc_valid_i, enc_ready_o, cw_valid_o, cw_ready_i;
  logic [10:0] enc_data_i;
  logic [15:0] cw_o;
  logic        dec_valid_i, dec_ready_o, dec_valid_o, dec_ready_i;
  logic [15:0] dec_cw_i;
  logic [10:0] dec_data_o;
  logic        dec_corr_o, dec_uncorr_o, clr_cnt_i;
  logic [3:0]  dec_synd_o;
  logic [15:0] ce_cnt_o, ue_cnt_o;

  logic        s_dec_valid_i, s_dec_ready_o, s_dec_valid_o, s_clr;
  logic [15:0] s_dec_cw_i;
  logic        s_enc_ready_o, s_cw_valid_o, s_dec_corr_o, s_dec_uncorr_o;
  logic [15:0] s_cw_o;
  logic [10:0] s_dec_data_o;
  logic [3:0]  s_dec_synd_o;
  logic [1:0]  s_ce_cnt_o, s_ue_cnt_o;

`ifdef HAMMING_ERR_INJECT_EN
  logic        inj_arm_i, inj_pend_o, s_inj_pend_o;
  logic [15:0] inj_mask_i;
`endif

  always #5 clk = ~clk;

  hamming_secded_pipe u_dut (
    .clk(clk), .rst_n(rst_n),
    .enc_valid_i(enc_valid_i), .enc_ready_o(enc_ready_o), .enc_data_i(enc_data_i),
    .cw_valid_o(cw_valid_o), .cw_ready_i(cw_ready_i), .cw_o(cw_o),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o), .dec_cw_i(dec_cw_i),
    .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i), .dec_data_o(dec_data_o),
    .dec_corr_o(dec_corr_o), .dec_uncorr_o(dec_uncorr_o), .dec_synd_o(dec_synd_o),
    .clr_cnt_i(clr_cnt_i), .ce_cnt_o(ce_cnt_o), .ue_cnt_o(ue_cnt_o)
`ifdef HAMMING_ERR_INJECT_EN
    , .inj_arm_i(inj_arm_i), .inj_mask_i(inj_mask_i), .inj_pend_o(inj_pend_o)
`endif
  );

  hamming_secded_pipe #(.CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .enc_valid_i(1'b0), .enc_ready_o(s_enc_ready_o), .enc_data_i(11'h0),
    .cw_valid_o(s_cw_valid_o), .cw_ready_i(1'b1), .cw_o(s_cw_o),
    .dec_valid_i(s_dec_valid_i), .dec_ready_o(s_dec_ready_o), .dec_cw_i(s_dec_cw_i),
    .dec_valid_o(s_dec_valid_o), .dec_ready_i(1'b1), .dec_data_o(s_dec_data_o),
    .dec_corr_o(s_dec_corr_o), .dec_uncorr_o(s_dec_uncorr_o), .dec_synd_o(s_dec_synd_o),
    .clr_cnt_i(s_clr), .ce_cnt_o(s_ce_cnt_o), .ue_cnt_o(s_ue_cnt_o)
`ifdef HAMMING_ERR_INJECT_EN
    , .inj_arm_i(1'b0), .inj_mask_i(16'h0), .inj_pend_o(s_inj_pend_o)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int exp_ce = 0;
  int exp_ue = 0;
  logic [15:0] enc_q[$];
  logic [16:0] dec_q[$];
  int          enc_cyc[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] enc_model(input logic [10:0] d);
    logic [15:0] c;
    int j;
    c = '0;
    j = 0;
    for (int pos = 1; pos < 16; pos++)
      if ((pos & (pos - 1)) != 0) begin
        c[pos] = d[j];
        j++;
      end
    c[1] = ^(c & 16'hAAAA);
    c[2] = ^(c & 16'hCCCC);
    c[4] = ^(c & 16'hF0F0);
    c[8] = ^(c & 16'hFF00);
    c[0] = ^c[15:1];
    return c;
  endfunction

  function automatic logic [10:0] extract_model(input logic [15:0] c);
    logic [10:0] d;
    int j;
    d = '0;
    j = 0;
    for (int pos = 1; pos < 16; pos++)
      if ((pos & (pos - 1)) != 0) begin
        d[j] = c[pos];
        j++;
      end
    return d;
  endfunction

  // Expected decode result derived from the known flipped positions.
  function automatic logic [16:0] dec_exp(input logic [10:0] d, input logic [15:0] flips);
    logic [3:0] s;
    s = '0;
    for (int pos = 0; pos < 16; pos++)
      if (flips[pos]) s = s ^ 4'(pos);
    case ($countones(flips))
      0:       return {d, 2'b00, 4'h0};
      1:       return {d, 2'b10, s};
      default: return {extract_model(enc_model(d) ^ flips), 2'b01, s};
    endcase
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (cw_valid_o && cw_ready_i) begin
        if (enc_q.size() == 0) check("enc_extra", 32'(enc_q.size()), 1);
        else begin
          check("enc_cw", 32'(cw_o), 32'(enc_q.pop_front()));
          enc_cyc.push_back(cyc);
        end
      end
      if (dec_valid_o && dec_ready_i) begin
        if (dec_q.size() == 0) check("dec_extra", 32'(dec_q.size()), 1);
        else check("dec_out", 32'({dec_data_o, dec_corr_o, dec_uncorr_o, dec_synd_o}),
                   32'(dec_q.pop_front()));
      end
    end
  end

  task automatic enc_send(input logic [10:0] d, input logic [15:0] exp);
    int n;
    logic r;
    n = 0;
    enc_valid_i = 1'b1;
    enc_data_i  = d;
    enc_q.push_back(exp);
    do begin
      @(negedge clk);
      r = enc_ready_o;
      @(posedge clk);
      n++;
    end while (!r && n < 60);
    if (!r) check("enc_timeout", 32'(r), 1);
    #1 enc_valid_i = 1'b0;
  endtask

  task automatic dec_send(input logic [15:0] cw, input logic [16:0] exp);
    int n;
    logic r;
    n = 0;
    dec_valid_i = 1'b1;
    dec_cw_i    = cw;
    dec_q.push_back(exp);
    if (exp[5]) exp_ce++;
    if (exp[4]) exp_ue++;
    do begin
      @(negedge clk);
      r = dec_ready_o;
      @(posedge clk);
      n++;
    end while (!r && n < 60);
    if (!r) check("dec_timeout", 32'(r), 1);
    #1 dec_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((enc_q.size() + dec_q.size()) != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain", 32'(enc_q.size() + dec_q.size()), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [10:0] d;
    logic [15:0] fl;
    int p1, p2;
    bit done4;
    rst_n = 1'b0; enc_valid_i = 1'b0; enc_data_i = '0; cw_ready_i = 1'b1;
    dec_valid_i = 1'b0; dec_cw_i = '0; dec_ready_i = 1'b1; clr_cnt_i = 1'b0;
    s_dec_valid_i = 1'b0; s_dec_cw_i = '0; s_clr = 1'b0;
`ifdef HAMMING_ERR_INJECT_EN
    inj_arm_i = 1'b0; inj_mask_i = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_cw_valid", 32'(cw_valid_o), 0);
    check("rst_dec_valid", 32'(dec_valid_o), 0);
    check("rst_cw", 32'(cw_o), 0);
    check("rst_dec_out", 32'({dec_data_o, dec_corr_o, dec_uncorr_o, dec_synd_o}), 0);
    check("rst_cnt", 32'({ce_cnt_o, ue_cnt_o}), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Spec vectors, back-to-back
    enc_cyc.delete();
    enc_send(11'h000, 16'h0000);
    enc_send(11'h7FF, 16'hFFFF);
    enc_send(11'h001, 16'h000F);
    drain();
    check("enc_b2b", 32'(enc_cyc[2] - enc_cyc[0]), 2);

    // Random encode under random backpressure
    fork
      begin
        repeat (40) begin
          @(posedge clk);
          #1 cw_ready_i = 1'($urandom_range(0, 1));
        end
        cw_ready_i = 1'b1;
      end
      begin
        for (int i = 0; i < 8; i++) begin
          d = 11'($urandom);
          enc_send(d, enc_model(d));
        end
      end
    join
    drain();

    dec_send(16'hFFFF ^ 16'h0020, {11'h7FF, 2'b10, 4'd5});
    drain();
    check("ce_after_pos5", 32'(ce_cnt_o), 1);
    dec_send(16'hFFFF ^ 16'h0001, {11'h7FF, 2'b10, 4'd0});
    dec_send(16'hFFFF ^ 16'h0006, {11'h7FF, 2'b01, 4'd3});
    drain();
    check("ce_after_dbl", 32'(ce_cnt_o), 2);
    check("ue_after_dbl", 32'(ue_cnt_o), 1);
    dec_send(enc_model(11'h155), {11'h155, 2'b00, 4'd0});

    // Random decode with 0/1/2 flips under random backpressure
    fork
      begin
        repeat (50) begin
          @(posedge clk);
          #1 dec_ready_i = 1'($urandom_range(0, 1));
        end
        dec_ready_i = 1'b1;
      end
      begin
        for (int i = 0; i < 12; i++) begin
          d  = 11'($urandom);
          fl = '0;
          p1 = $urandom_range(0, 15);
          p2 = (p1 + $urandom_range(1, 15)) % 16;
          if (i % 3 >= 1) fl[p1] = 1'b1;
          if (i % 3 == 2) fl[p2] = 1'b1;
          dec_send(enc_model(d) ^ fl, dec_exp(d, fl));
        end
      end
    join
    drain();
    check("ce_random", 32'(ce_cnt_o), 32'(exp_ce));
    check("ue_random", 32'(ue_cnt_o), 32'(exp_ue));

    // Stall: three single-error words with output ready held low
    dec_ready_i = 1'b0;
    done4 = 1'b0;
    fork
      begin
        dec_send(enc_model(11'h123) ^ 16'h0400, dec_exp(11'h123, 16'h0400));
        dec_send(enc_model(11'h456) ^ 16'h0004, dec_exp(11'h456, 16'h0004));
        dec_send(enc_model(11'h789) ^ 16'h8000, dec_exp(11'h789, 16'h8000));
        done4 = 1'b1;
      end
    join_none
    repeat (4) @(negedge clk);
    check("stall_ready", 32'(dec_ready_o), 0);
    check("stall_valid", 32'(dec_valid_o), 1);
    repeat (2) @(posedge clk);
    #1 dec_ready_i = 1'b1;
    for (int n = 0; n < 100 && !done4; n++) @(posedge clk);
    check("stall_done", 32'(done4), 1);
    drain();
    check("ce_stall", 32'(ce_cnt_o), 32'(exp_ce));

    // Saturation on the 2-bit counter instance
    s_dec_cw_i = 16'hFFFF ^ 16'h0020;
    for (int k = 0; k < 5; k++) begin
      s_dec_valid_i = 1'b1;
      @(posedge clk);
      #1 s_dec_valid_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("sat_ce", 32'(s_ce_cnt_o), (k < 3) ? k + 1 : 3);
    end
    s_dec_valid_i = 1'b1;
    @(posedge clk);
    #1 s_dec_valid_i = 1'b0;
    for (int n = 0; n < 10 && !s_dec_valid_o; n++) @(negedge clk);
    check("sat_pre_clr", 32'({s_dec_valid_o, s_ce_cnt_o}), 32'h7);
    s_clr = 1'b1;
    @(posedge clk);
    #1 s_clr = 1'b0;
    check("sat_clr", 32'(s_ce_cnt_o), 0);
    repeat (2) @(posedge clk);
    #1;
    check("sat_clr_hold", 32'({s_ce_cnt_o, s_ue_cnt_o}), 0);

    // Mid-operation reset with both pipes full
    cw_ready_i = 1'b0; dec_ready_i = 1'b0;
    enc_valid_i = 1'b1; enc_data_i = 11'h2AA;
    dec_valid_i = 1'b1; dec_cw_i = 16'h1234;
    repeat (3) @(posedge clk);
    #1;
    check("full_pre_rst", 32'({cw_valid_o, dec_valid_o, dec_ready_o}), 32'b110);
    rst_n = 1'b0; enc_valid_i = 1'b0; dec_valid_i = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_mid_valid", 32'({cw_valid_o, dec_valid_o}), 0);
    check("rst_mid_cnt", 32'({ce_cnt_o, ue_cnt_o}), 0);
    cw_ready_i = 1'b1; dec_ready_i = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_no_emit", 32'({cw_valid_o, dec_valid_o}), 0);

`ifdef HAMMING_ERR_INJECT_EN
    inj_arm_i = 1'b1; inj_mask_i = 16'h0100;
    @(posedge clk);
    #1 inj_arm_i = 1'b0;
    check("inj_pend_set", 32'(inj_pend_o), 1);
    enc_send(11'h000, 16'h0100);
    check("inj_pend_clr", 32'(inj_pend_o), 0);
    inj_arm_i = 1'b1; inj_mask_i = 16'h8000;
    enc_send(11'h7FF, 16'h7FFF);
    inj_arm_i = 1'b0;
    check("inj_same_cyc_pend", 32'(inj_pend_o), 0);
    enc_send(11'h7FF, 16'hFFFF);
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
